// File: rtl/seq_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul_pkg
// Purpose  : Shared types and constants for the seq_mul sequential multiplier.
// Revision : 1.0  initial release
// ============================================================================
package seq_mul_pkg;

    localparam int MUL_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage : seq_mul_pkg
`default_nettype wire

// File: rtl/seq_mul_add_nbit.sv
`default_nettype none
// ============================================================================
// Module   : add_nbit
// Purpose  : Parametrised N-bit ripple-carry adder built from full-adder cells.
// Revision : 1.0  initial release
// ============================================================================
module add_nbit #(
    parameter int N = 16
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    logic [N:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign o_sum[i]     = i_a[i] ^ i_b[i] ^ w_carry[i];
        assign w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_carry[N];

endmodule : add_nbit
`default_nettype wire

// File: rtl/seq_mul.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul
// Purpose  : Unsigned shift-and-add multiplier, one partial product per clock,
//            valid/ready on both sides. Optional SEQ_MUL_EARLY_EXIT_EN ends
//            the iteration once no multiplier bits remain.
// Revision : 1.0  initial release
// ============================================================================
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int W = MUL_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);

    localparam int                C_CNT_W    = cnt_width(W);
    localparam logic [C_CNT_W-1:0] C_LAST_CNT = C_CNT_W'(W - 1);

    state_t               r_state;
    logic [2*W-1:0]       r_acc;
    logic [2*W-1:0]       r_mcand;
    logic [W-1:0]         r_mplier;
    logic [C_CNT_W-1:0]   r_count;

    logic [2*W-1:0]       w_addend;
    logic [2*W-1:0]       w_sum;
    logic                 w_cout_unused;
    logic                 w_last;

    assign w_addend = r_mplier[0] ? r_mcand : '0;

    // The product always fits in 2W bits, so the carry-out is never set.
    add_nbit #(
        .N      (2 * W)
    ) u_add (
        .i_a    (r_acc),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout_unused)
    );

`ifdef SEQ_MUL_EARLY_EXIT_EN
    assign w_last = (r_count == C_LAST_CNT) || ((r_mplier >> 1) == '0);
`else
    assign w_last = (r_count == C_LAST_CNT);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= {{W{1'b0}}, a};
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (w_last) begin
                        r_state <= DONE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN) || (r_state == DONE);
    assign product   = r_acc;

endmodule : seq_mul
`default_nettype wire

// File: tb/tb_seq_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mul
// Purpose  : Directed self-checking bench for seq_mul (W=8 and W=4 instances).
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_mul;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid8  = 1'b0;
    logic        out_ready8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        in_ready8, out_valid8, busy8;
    logic [15:0] product8;

    logic        in_valid4  = 1'b0;
    logic        out_ready4 = 1'b1;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        in_ready4, out_valid4, busy4;
    logic [7:0]  product4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_mul #(.W(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .product   (product8),
        .busy      (busy8)
    );

    seq_mul #(.W(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .product   (product4),
        .busy      (busy4)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [7:0] bv);
        int l;
        l = 1;
        for (int i = 0; i < 8; i++) begin
            if (bv[i]) l = i + 1;
        end
`ifdef SEQ_MUL_EARLY_EXIT_EN
        return l;
`else
        return (l > 0) ? 8 : 8;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready8();
        int n;
        n = 0;
        while (!in_ready8 && n < 50) begin
            tick();
            n++;
        end
        check_val("ready_wait", {63'd0, in_ready8}, 64'd1);
    endtask

    task automatic accept8(input logic [7:0] av, input logic [7:0] bv);
        wait_ready8();
        a8        = av;
        b8        = bv;
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        check_val("accept_in_ready", {63'd0, in_ready8}, 64'd0);
        check_val("accept_busy", {63'd0, busy8}, 64'd1);
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic [15:0] exp, input int hold);
        int n;
        accept8(av, bv);
        n = 0;
        while (!out_valid8 && n < 64) begin
            tick();
            n++;
        end
        check_val("latency", n, exp_lat(bv));
        check_val("product", {48'd0, product8}, {48'd0, exp});
        for (int k = 0; k < hold; k++) begin
            tick();
            check_val("hold_product", {48'd0, product8}, {48'd0, exp});
            check_val("hold_valid", {63'd0, out_valid8}, 64'd1);
            check_val("hold_in_ready", {63'd0, in_ready8}, 64'd0);
        end
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        check_val("post_valid", {63'd0, out_valid8}, 64'd0);
        check_val("post_in_ready", {63'd0, in_ready8}, 64'd1);
    endtask

    initial begin
        int n, acc0, acc1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_in_ready", {63'd0, in_ready8}, 64'd1);
        check_val("rst_out_valid", {63'd0, out_valid8}, 64'd0);
        check_val("rst_busy", {63'd0, busy8}, 64'd0);
        check_val("rst_product", {48'd0, product8}, 64'd0);

        run_op(8'd13, 8'd11, 16'd143, 0);
        run_op(8'd255, 8'd255, 16'd65025, 0);
        run_op(8'd0, 8'd200, 16'd0, 0);
        run_op(8'd7, 8'd9, 16'd63, 5);
        run_op(8'd50, 8'd3, 16'd150, 0);
        run_op(8'd77, 8'd0, 16'd0, 0);
        run_op(8'd2, 8'd128, 16'd256, 0);

        // Reset lands on the fourth RUN edge; the operation must vanish.
        accept8(8'd100, 8'd100);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("midrst_in_ready", {63'd0, in_ready8}, 64'd1);
        check_val("midrst_out_valid", {63'd0, out_valid8}, 64'd0);
        check_val("midrst_product", {48'd0, product8}, 64'd0);
        check_val("midrst_busy", {63'd0, busy8}, 64'd0);
        run_op(8'd3, 8'd5, 16'd15, 0);

        // W=4 back-to-back with in_valid and out_ready held high.
        a4        = 4'd15;
        b4        = 4'd15;
        in_valid4 = 1'b1;
        n = 0;
        while (!in_ready4 && n < 50) begin tick(); n++; end
        tick();
        acc0 = cyc;
        n = 0;
        while (!out_valid4 && n < 50) begin tick(); n++; end
        check_val("b2b_product0", {56'd0, product4}, 64'd225);
        check_val("b2b_in_ready_done", {63'd0, in_ready4}, 64'd0);
        a4 = 4'd2;
        b4 = 4'd3;
        n = 0;
        while (!in_ready4 && n < 50) begin tick(); n++; end
        tick();
        acc1 = cyc;
        in_valid4 = 1'b0;
        check_val("b2b_interval", acc1 - acc0, 64'd6);
        n = 0;
        while (!out_valid4 && n < 50) begin tick(); n++; end
        check_val("b2b_product1", {56'd0, product4}, 64'd6);
        tick();
        check_val("b2b_idle", {63'd0, in_ready4}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_seq_mul
`default_nettype wire
